conv_window_stream: RTL and testbench

Streaming window generator that produces the 3x3 pixel neighbourhoods consumed by `convolution`/`conv`. It accepts a raster-order pixel stream (one 32-bit pixel per transfer), stores the two previous image rows in line buffers, and emits one 3x3 window per valid-convolution output position, giving a (W-2)x(H-2) output grid. Sits between the DDR3 read path and the convolution datapath.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/line_buffer.sv | 29 ++
 rtl/conv_window_stream.sv | 146 ++++++++++++++
 tb/tb_conv_window_stream.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : shared pixel/window types and 3x3 window index helpers
// Revision : 1.0
// ============================================================================
package conv_pkg;

  localparam int PIX_W = 32;

  typedef logic [PIX_W-1:0]       pix_t;
  typedef logic [8:0][PIX_W-1:0]  pix_window_t;

  localparam int K_TL = 0;
  localparam int K_C  = 4;
  localparam int K_BR = 8;

  // Flat window index for neighbourhood row dr and column dc (both 0..2).
  function automatic logic [3:0] win_idx(input int dr, input int dc);
    return 4'(3 * dr + dc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// line_buffer : one-row pixel store, read and write at the same index per enable
// Revision    : 1.0
// ============================================================================
module line_buffer #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Asynchronous read returns the old entry in the same cycle it is overwritten.
  assign rdata = mem_q[idx];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[idx] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_stream.sv
`default_nettype none
// ============================================================================
// conv_window_stream : 3x3 sliding-window generator over a raster pixel stream
// Revision           : 1.0
// ============================================================================
module conv_window_stream #(
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 10,
  parameter int PIX_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sof,
  input  logic [PIX_W-1:0]              in_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [8:0][PIX_W-1:0]         out_window,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic                          out_last
);
  import conv_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d, eff_col;
  logic [RW-1:0] row_q, row_d, eff_row;

  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [2:0][PIX_W-1:0] new_col;
  // Two previous columns per window row; the third column comes live from new_col.
  logic [2:0][1:0][PIX_W-1:0] sh_q, sh_d;

  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q,  out_last_d;
  logic [8:0][PIX_W-1:0] out_window_q, out_window_d;
  logic [RW-1:0]         out_row_q, out_row_d;
  logic [CW-1:0]         out_col_q, out_col_d;

  logic in_fire;
  logic emit;

  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign eff_col = in_sof ? '0 : col_q;
  assign eff_row = in_sof ? '0 : row_q;
  assign emit    = in_fire && (eff_row >= RW'(2)) && (eff_col >= CW'(2));

  assign new_col[0] = lb2_rd;
  assign new_col[1] = lb1_rd;
  assign new_col[2] = in_pixel;

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb_prev1 (
    .clk   (clk),
    .en    (in_fire),
    .idx   (eff_col),
    .wdata (in_pixel),
    .rdata (lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb_prev2 (
    .clk   (clk),
    .en    (in_fire),
    .idx   (eff_col),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    sh_d         = sh_q;
    out_valid_d  = out_valid_q;
    out_window_d = out_window_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    out_last_d   = out_last_q;

    if (in_fire) begin
      if (eff_col == COL_MAX) begin
        col_d = '0;
        row_d = (eff_row == ROW_MAX) ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
      for (int dr = 0; dr < 3; dr++) begin
        sh_d[dr][0] = sh_q[dr][1];
        sh_d[dr][1] = new_col[dr];
      end
    end

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      for (int dr = 0; dr < 3; dr++) begin
        out_window_d[win_idx(dr, 0)] = sh_q[dr][0];
        out_window_d[win_idx(dr, 1)] = sh_q[dr][1];
        out_window_d[win_idx(dr, 2)] = new_col[dr];
      end
      out_row_d  = eff_row - RW'(2);
      out_col_d  = eff_col - CW'(2);
      out_last_d = (eff_row == ROW_MAX) && (eff_col == COL_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      sh_q         <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_last_q   <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      sh_q         <= sh_d;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_last   = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_conv_window_stream : randomized bench against a frame-array reference model
// Revision              : 1.0
// ============================================================================
module tb_conv_window_stream;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready, in_sof, out_valid, out_ready, out_last;
  logic [PW-1:0]        in_pixel;
  logic [8:0][PW-1:0]   out_window;
  logic [3:0]           out_row, out_col;

  logic                 s_in_valid, s_in_ready, s_in_sof, s_out_valid, s_out_ready, s_out_last;
  logic [PW-1:0]        s_in_pixel;
  logic [8:0][PW-1:0]   s_out_window;
  logic [1:0]           s_out_row, s_out_col;

  conv_window_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  conv_window_stream #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIX_W(PW)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sof(s_in_sof), .in_pixel(s_in_pixel),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_window(s_out_window),
    .out_row(s_out_row), .out_col(s_out_col), .out_last(s_out_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [8:0][PW-1:0] win;
    int                 row;
    int                 col;
    bit                 last;
  } exp_t;

  exp_t          q[$];
  logic [PW-1:0] img [H][W];
  int            mrow = 0, mcol = 0;

  int                 n_pop;
  bit                 got_first;
  logic [8:0][PW-1:0] first_win, last_win;
  int                 last_row, last_col;
  bit                 last_last;
  int                 rdy_mode, bp_cnt;
  bit                 bp_done;

  // Reference: store the pixel in the frame image, and whenever it completes a
  // 3x3 neighbourhood, queue the expected window read straight from the image.
  task automatic model_accept(input logic [PW-1:0] pix, input bit sof);
    exp_t e;
    if (sof) begin mrow = 0; mcol = 0; end
    img[mrow][mcol] = pix;
    if (mrow >= 2 && mcol >= 2) begin
      for (int k = 0; k < 9; k++) e.win[k] = img[mrow - 2 + k / 3][mcol - 2 + k % 3];
      e.row  = mrow - 2;
      e.col  = mcol - 2;
      e.last = (mrow == H - 1) && (mcol == W - 1);
      q.push_back(e);
    end
    mcol++;
    if (mcol == W) begin
      mcol = 0;
      mrow++;
      if (mrow == H) mrow = 0;
    end
  endtask

  task automatic cycle(input bit v, input bit sof, input logic [PW-1:0] pix, output bit ifire);
    bit   rdy, ofire;
    exp_t e;
    @(negedge clk);
    case (rdy_mode)
      0: rdy = 1'b1;
      1: rdy = ($urandom_range(0, 99) < 60);
      default: begin
        rdy = 1'b1;
        if (!bp_done && q.size() != 0) begin
          bp_cnt++;
          if (bp_cnt <= 5) rdy = 1'b0;
          else bp_done = 1'b1;
        end
      end
    endcase
    in_valid  = v;
    in_sof    = sof;
    in_pixel  = pix;
    out_ready = rdy;
    #1;
    check("out_valid", out_valid, q.size() != 0);
    check("in_ready", in_ready, (q.size() == 0) || rdy);
    if (q.size() != 0) begin
      check("window", out_window, q[0].win);
      check("out_row", out_row, q[0].row);
      check("out_col", out_col, q[0].col);
      check("out_last", out_last, q[0].last);
    end
    ofire = out_valid && rdy;
    ifire = v && in_ready;
    if (ofire && q.size() != 0) begin
      e = q.pop_front();
      n_pop++;
      if (!got_first) begin first_win = out_window; got_first = 1'b1; end
      last_win  = out_window;
      last_row  = out_row;
      last_col  = out_col;
      last_last = out_last;
    end
    if (ifire) model_accept(pix, sof);
  endtask

  task automatic send(input logic [PW-1:0] pix, input bit sof, input int pv_pct);
    bit f, v;
    int n;
    f = 1'b0;
    n = 0;
    while (!f && n < 200) begin
      v = ($urandom_range(0, 99) < pv_pct);
      cycle(v, sof, pix, f);
      n++;
    end
    if (!f) check("send_timeout", 0, 1);
  endtask

  // pat=1 drives pixel value 10*row+col, otherwise random data.
  task automatic send_frame(input int npix, input bit sof_first, input bit pat, input int pv_pct);
    logic [PW-1:0] pix;
    bit            sof;
    for (int i = 0; i < npix; i++) begin
      sof = sof_first && (i == 0);
      if (pat) pix = sof ? 32'd0 : 32'(10 * mrow + mcol);
      else     pix = $urandom;
      send(pix, sof, pv_pct);
    end
  endtask

  task automatic drain();
    bit f;
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      cycle(1'b0, 1'b0, '0, f);
      n++;
    end
    cycle(1'b0, 1'b0, '0, f);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0][PW-1:0] exp_win;

    in_valid = 0; in_sof = 0; in_pixel = '0; out_ready = 0;
    s_in_valid = 0; s_in_sof = 0; s_in_pixel = '0; s_out_ready = 0;
    rdy_mode = 0; bp_cnt = 0; bp_done = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_window", out_window, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Directed frame, pixel = 10*r + c, downstream always ready.
    n_pop = 0; got_first = 0;
    send_frame(100, 1'b0, 1'b1, 100);
    drain();
    check("t1_count", n_pop, 64);
    for (int k = 0; k < 9; k++) exp_win[k] = 32'(10 * (k / 3) + (k % 3));
    check("t1_first_window", first_win, exp_win);
    check("t1_last_centre", last_win[4], 88);
    check("t1_last_flag", last_last, 1);
    check("t1_last_row", last_row, 7);
    check("t1_last_col", last_col, 7);

    // Backpressure: out_ready low for 5 cycles once the first window appears.
    rdy_mode = 2; bp_cnt = 0; bp_done = 0; n_pop = 0;
    send_frame(100, 1'b0, 1'b1, 100);
    drain();
    check("t2_count", n_pop, 64);

    // Random input gaps and random downstream ready, two frames of random data.
    rdy_mode = 1; n_pop = 0;
    send_frame(100, 1'b0, 1'b0, 70);
    send_frame(100, 1'b0, 1'b0, 70);
    drain();
    check("t3_count", n_pop, 128);

    // Start-of-frame in the middle of a frame, at position (4,5).
    send_frame(45, 1'b0, 1'b0, 80);
    drain();
    n_pop = 0;
    send_frame(100, 1'b1, 1'b0, 80);
    drain();
    check("t4_count", n_pop, 64);

    // Reset in the middle of a frame, at position (5,5).
    send_frame(55, 1'b0, 1'b0, 80);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_last", out_last, 0);
    check("t5_rst_out_row", out_row, 0);
    check("t5_rst_in_ready", in_ready, 1);
    q.delete();
    mrow = 0; mcol = 0;
    @(negedge clk);
    rst_n = 1'b1;
    n_pop = 0;
    send_frame(100, 1'b0, 1'b0, 100);
    drain();
    check("t5_count", n_pop, 64);

    // Minimal 3x3 image: exactly one window holding pixels 1..9.
    s_out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_sof   = (i == 1);
      s_in_pixel = 32'(i);
      #1;
      check("s_in_ready", s_in_ready, 1);
      check("s_early_valid", s_out_valid, 0);
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    s_in_sof   = 1'b0;
    #1;
    for (int k = 0; k < 9; k++) exp_win[k] = 32'(k + 1);
    check("s_out_valid", s_out_valid, 1);
    check("s_window", s_out_window, exp_win);
    check("s_out_last", s_out_last, 1);
    check("s_out_row", s_out_row, 0);
    check("s_out_col", s_out_col, 0);
    @(negedge clk);
    #1;
    check("s_valid_cleared", s_out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
